// File: rtl/frame_buf_sched.sv
// Frame-buffer scheduler: hands DDR buffers to the frame writer and reader so that a read is never overwritten.
// Optional drop statistics are built when FRAME_SCHED_STATS_EN is defined; otherwise drop_count is tied to 0.
module frame_buf_sched #(
   parameter int                NUM_BUF    = 3,
   parameter int                ADDR_W     = 29,
   parameter logic [ADDR_W-1:0] BUF_BASE   = 29'h0000000,
   parameter logic [ADDR_W-1:0] BUF_STRIDE = 29'h0100000
) (
   input  logic              clk_100,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              wr_start_frame,
   input  logic              wr_end_frame,
   input  logic              rd_start_frame,
   input  logic              rd_end_frame,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        wr_buf_idx,
   output logic              wr_active,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [1:0]        rd_buf_idx,
   output logic              rd_valid,
   output logic              rd_active,
   output logic              frame_dropped,
   output logic [15:0]       drop_count,
   output logic [1:0]        wr_state
);

   // All frame strobes are single-cycle pulses sampled on clk_100; there is no
   // back-pressure, so wr_addr/wr_buf_idx must already be valid when wr_start_frame rises.
   typedef enum logic [1:0] {W_OFF = 2'd0, W_WAIT = 2'd1, W_WRITE = 2'd2} w_state_t;

   localparam logic [1:0] B_FREE    = 2'd0;
   localparam logic [1:0] B_WRITING = 2'd1;
   localparam logic [1:0] B_READY   = 2'd2;
   localparam logic [1:0] B_READING = 2'd3;

   w_state_t   state_q, state_n;
   logic       start_ok, end_ok;
   logic [1:0] buf_st [4];
   logic [1:0] nxt_st [4];
   logic       have_ready, have_wr, claim, rd_accept, drop, rd_valid_n;
   logic [1:0] ready_idx, wr_cur, tgt, sel_idx, rd_idx_n;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] idx);
      return BUF_BASE + ADDR_W'(idx) * BUF_STRIDE;
   endfunction

   assign wr_state = state_q;

   always_comb begin
      state_n  = state_q;
      start_ok = 1'b0;
      end_ok   = 1'b0;
      case (state_q)
         W_OFF: if (enable) state_n = W_WAIT;
         W_WAIT: begin
            if (!enable) state_n = W_OFF;
            else if (wr_start_frame) begin
               state_n  = W_WRITE;
               start_ok = 1'b1;
            end
         end
         W_WRITE: begin
            if (wr_end_frame) begin
               end_ok  = 1'b1;
               state_n = enable ? W_WAIT : W_OFF;
            end
            // A start with end in the same cycle chains frames; without end it aborts.
            if (wr_start_frame && enable) begin
               start_ok = 1'b1;
               state_n  = W_WRITE;
            end
         end
         default: state_n = W_OFF;
      endcase
   end

   always_comb begin
      nxt_st     = buf_st;
      drop       = 1'b0;
      rd_idx_n   = rd_buf_idx;
      rd_valid_n = rd_valid;
      have_ready = 1'b0;
      ready_idx  = 2'd0;
      have_wr    = 1'b0;
      wr_cur     = 2'd0;
      tgt        = wr_buf_idx;
      sel_idx    = 2'd0;
      for (int i = 0; i < NUM_BUF; i++) begin
         if (buf_st[2'(i)] == B_READY) begin
            have_ready = 1'b1;
            ready_idx  = 2'(i);
         end
         if (buf_st[2'(i)] == B_WRITING) begin
            have_wr = 1'b1;
            wr_cur  = 2'(i);
         end
      end

      // Reader claims the READY buffer as it stood before this cycle.
      claim     = rd_start_frame && have_ready;
      rd_accept = rd_start_frame && (have_ready || rd_valid);
      if (claim) begin
         if (rd_valid) nxt_st[rd_buf_idx] = B_FREE;
         nxt_st[ready_idx] = B_READING;
         rd_idx_n          = ready_idx;
         rd_valid_n        = 1'b1;
      end

      if (end_ok) begin
         if (have_ready && !claim) begin
            nxt_st[ready_idx] = B_FREE;
            drop              = 1'b1;
         end
         nxt_st[wr_cur] = B_READY;
      end

      if (start_ok) begin
         if (have_wr && !end_ok) begin
            nxt_st[wr_cur] = B_FREE;
            drop           = 1'b1;
         end
         // The look-ahead READY buffer may be claimed this very cycle; fall back to
         // the buffer the reader just released, or the writer's own buffer.
         if (claim && (tgt == ready_idx)) tgt = rd_valid ? rd_buf_idx : wr_cur;
         if (nxt_st[tgt] == B_READY) drop = 1'b1;
         nxt_st[tgt] = B_WRITING;
      end

      // Priority by overwrite: lowest FREE, else READY, else the writer's own buffer
      // (only reachable with two buffers, where a restart can only reuse it).
      for (int i = 0; i < NUM_BUF; i++)
         if (nxt_st[2'(i)] == B_WRITING) sel_idx = 2'(i);
      for (int i = 0; i < NUM_BUF; i++)
         if (nxt_st[2'(i)] == B_READY) sel_idx = 2'(i);
      for (int i = NUM_BUF - 1; i >= 0; i--)
         if (nxt_st[2'(i)] == B_FREE) sel_idx = 2'(i);
   end

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= W_OFF;
         buf_st        <= '{default: B_FREE};
         wr_buf_idx    <= 2'd0;
         wr_addr       <= BUF_BASE;
         rd_buf_idx    <= 2'd0;
         rd_addr       <= BUF_BASE;
         rd_valid      <= 1'b0;
         wr_active     <= 1'b0;
         rd_active     <= 1'b0;
         frame_dropped <= 1'b0;
      end else begin
         state_q       <= state_n;
         buf_st        <= nxt_st;
         wr_buf_idx    <= sel_idx;
         wr_addr       <= addr_of(sel_idx);
         rd_buf_idx    <= rd_idx_n;
         rd_addr       <= addr_of(rd_idx_n);
         rd_valid      <= rd_valid_n;
         wr_active     <= (state_n == W_WRITE);
         frame_dropped <= drop;
         if (rd_accept) rd_active <= 1'b1;
         else if (rd_end_frame) rd_active <= 1'b0;
      end
   end

`ifdef FRAME_SCHED_STATS_EN
   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) drop_count <= 16'h0000;
      else if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'h0001;
   end
`else
   assign drop_count = 16'h0000;
`endif

endmodule
